hmac_job_sched: RTL and testbench

- Shares one HMAC-SHA256 core (top_hmac) between NUM_REQ requesters, e.g. the secure-boot checker, the debug authenticator and the AXI-lite register front end.
- Arbitrates round-robin and latches the winner's 512-bit message block. Pulses the core's init and waits for the core's data_available.
- Captures the 256-bit result, compares it with the requester's expected hash, and returns done, match and hash to that requester.
- Raises a sticky warning on mismatch or timeout.
- Sits between the requesters and top_hmac. The key path into the core is unchanged and does not pass through this block.

---
 rtl/hmac_sched_pkg.sv | 15 +
 rtl/rr_arbiter_onehot.sv | 27 ++
 rtl/hmac_job_sched.sv | 162 ++++++++++++++++
 tb/tb_hmac_job_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hmac_sched_pkg.sv
// Shared widths and FSM state encoding for the HMAC job scheduler.
package hmac_sched_pkg;

  localparam int unsigned HASH_W  = 256;
  localparam int unsigned BLK_W   = 512;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD      = 3'd1;
  localparam logic [STATE_W-1:0] S_START     = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT_ACK  = 3'd3;
  localparam logic [STATE_W-1:0] S_WAIT_DONE = 3'd4;
  localparam logic [STATE_W-1:0] S_RESP      = 3'd5;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin pick: first request at or above the pointer, wrapping.
module rr_arbiter_onehot #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_idx = PTR_W'((32'(i_ptr) + off) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hmac_job_sched.sv
// Time-shares one HMAC-SHA256 core between NUM_REQ requesters, checking each
// result against the requester's expected hash.
module hmac_job_sched
  import hmac_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*BLK_W-1:0]  data_i,
  input  logic [NUM_REQ*HASH_W-1:0] exp_hash_i,
  input  logic                      lock_i,
  input  logic                      warn_clr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      match_o,
  output logic [HASH_W-1:0]         hash_o,
  output logic                      timeout_o,
  output logic                      busy_o,
  output logic                      warning_o,
  output logic                      core_init_o,
  output logic [BLK_W-1:0]          core_data_o,
  input  logic [HASH_W-1:0]         core_hash_i,
  input  logic                      core_valid_i
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [STATE_W-1:0] r_state, w_nxt_state;
  logic [PTR_W-1:0]   r_ptr, r_idx, w_win_idx;
  logic [NUM_REQ-1:0] r_gnt, r_done, w_arb_gnt;
  logic [BLK_W-1:0]   r_data, w_blk_sel;
  logic [HASH_W-1:0]  r_exp, r_hash, w_exp_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_match, r_to, r_warn, r_init, r_busy;
  logic               w_launch, w_cnt_exp;

  rr_arbiter_onehot #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  assign w_launch  = (r_state == S_IDLE) && !lock_i && (req_i != '0);
  assign w_cnt_exp = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Index of the arbiter winner and the latched requester's payload slices.
  always_comb begin
    w_win_idx = '0;
    w_blk_sel = '0;
    w_exp_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_arb_gnt[i]) w_win_idx = PTR_W'(i);
      if (r_idx == PTR_W'(i)) begin
        w_blk_sel = data_i[i*BLK_W +: BLK_W];
        w_exp_sel = exp_hash_i[i*HASH_W +: HASH_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nxt_state;
  end

  // WAIT_ACK lets timeout win; WAIT_DONE lets a valid result win a tie.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:      if (w_launch) w_nxt_state = S_LOAD;
      S_LOAD:      w_nxt_state = S_START;
      S_START:     w_nxt_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (w_cnt_exp)          w_nxt_state = S_RESP;
        else if (!core_valid_i) w_nxt_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (core_valid_i || w_cnt_exp) w_nxt_state = S_RESP;
      S_RESP:      w_nxt_state = S_IDLE;
      default:     w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_data  <= '0;
      r_exp   <= '0;
      r_hash  <= '0;
      r_cnt   <= '0;
      r_match <= 1'b0;
      r_to    <= 1'b0;
      r_init  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_init  <= (r_state == S_LOAD);
      r_busy  <= (w_nxt_state != S_IDLE);
      r_done  <= '0;
      r_match <= 1'b0;
      r_to    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_gnt <= w_arb_gnt;
            r_idx <= w_win_idx;
            r_ptr <= (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
          end
        end
        S_LOAD: begin
          r_data <= w_blk_sel;
          r_exp  <= w_exp_sel;
        end
        S_START: r_cnt <= '0;
        S_WAIT_ACK: begin
          if (w_cnt_exp) begin
            r_done <= r_gnt;
            r_to   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (core_valid_i) begin
            r_hash  <= core_hash_i;
            r_done  <= r_gnt;
            r_match <= (core_hash_i == r_exp);
          end else if (w_cnt_exp) begin
            r_done <= r_gnt;
            r_to   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP:  r_gnt <= '0;
        default: r_gnt <= '0;
      endcase
    end
  end

  // Sticky warning: a failed compare in RESP beats a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                             r_warn <= 1'b0;
    else if (r_state == S_RESP && !r_match) r_warn <= 1'b1;
    else if (warn_clr_i)                   r_warn <= 1'b0;
  end

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign match_o     = r_match;
  assign hash_o      = r_hash;
  assign timeout_o   = r_to;
  assign busy_o      = r_busy;
  assign warning_o   = r_warn;
  assign core_init_o = r_init;
  assign core_data_o = r_data;

endmodule

// File: tb/tb_hmac_job_sched.sv
// Randomized self-checking bench for hmac_job_sched against a job-level model.
module tb_hmac_job_sched;

  localparam int NR = 4;
  localparam int T  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_i = '0;
  logic [NR*512-1:0] data_i = '0;
  logic [NR*256-1:0] exp_hash_i = '0;
  logic              lock_i = 1'b0;
  logic              warn_clr_i = 1'b0;
  logic [NR-1:0]     gnt_o, done_o;
  logic              match_o, timeout_o, busy_o, warning_o, core_init_o;
  logic [255:0]      hash_o;
  logic [511:0]      core_data_o;
  logic [255:0]      core_hash_i = '0;
  logic              core_valid_i = 1'b0;

  int errs = 0;
  int checks = 0;

  int           m_ptr = 0;
  logic         m_warn = 1'b0;
  logic [255:0] m_hash = '0;

  always #5 clk = ~clk;

  hmac_job_sched #(.NUM_REQ(NR), .TIMEOUT_CYCLES(T)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req_i),
    .data_i       (data_i),
    .exp_hash_i   (exp_hash_i),
    .lock_i       (lock_i),
    .warn_clr_i   (warn_clr_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .match_o      (match_o),
    .hash_o       (hash_o),
    .timeout_o    (timeout_o),
    .busy_o       (busy_o),
    .warning_o    (warning_o),
    .core_init_o  (core_init_o),
    .core_data_o  (core_data_o),
    .core_hash_i  (core_hash_i),
    .core_valid_i (core_valid_i)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_inputs();
    for (int i = 0; i < NR * 16; i++) data_i[i*32 +: 32] = $urandom;
    for (int i = 0; i < NR * 8; i++) exp_hash_i[i*32 +: 32] = $urandom;
  endtask

  // First requester at or after the pointer, searching upward with wrap.
  function automatic int rr_pick(input int p, input logic [NR-1:0] r);
    for (int off = 0; off < NR; off++)
      if (r[(p + off) % NR]) return (p + off) % NR;
    return -1;
  endfunction

  // One job: core holds a stale valid for s cycles after init, drops it for g
  // cycles, then asserts it. Done is expected min(s+g,T)+1 cycles after init.
  task automatic run_job(input logic [NR-1:0] req, input int s, input int g,
                         input bit good, input bit clr_resp, input bit disturb,
                         input bit clr_idle);
    int w, k, kd, exp_k;
    bit to;
    logic [511:0] blk;
    logic [255:0] eh, hv;
    w = rr_pick(m_ptr, req);
    req_i = req;
    warn_clr_i = clr_idle;
    if (clr_idle) m_warn = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      warn_clr_i = 1'b0;
      k++;
    end while (gnt_o == '0 && k < 10);
    chk("gnt", 512'(gnt_o), 512'(1 << w));
    m_ptr = (w + 1) % NR;
    blk = data_i[w*512 +: 512];
    eh  = exp_hash_i[w*256 +: 256];
    k = 0;
    while (core_init_o !== 1'b1 && k < 5) begin
      @(negedge clk);
      k++;
    end
    chk("init_seen", 512'(core_init_o), 512'(1));
    chk("core_data", core_data_o, blk);
    if (disturb) begin
      fill_inputs();
      req_i  = NR'($urandom);
      lock_i = 1'($urandom);
    end
    hv = good ? eh : (eh ^ {1'b1, 255'b0});
    core_hash_i = hv;
    to = (s + g > T);
    exp_k = (to ? T : s + g) + 1;
    kd = -1;
    for (int j = 0; j <= T + 10; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) chk("init_pulse", 512'(core_init_o), 512'(0));
      if (done_o != '0) begin
        kd = j;
        break;
      end
      core_valid_i = (j < s) ? 1'b1 : ((j < s + g) ? 1'b0 : 1'b1);
    end
    chk("done_cycle", 512'(kd), 512'(exp_k));
    chk("done", 512'(done_o), 512'(1 << w));
    chk("timeout", 512'(timeout_o), 512'(to));
    chk("match", 512'(match_o), 512'(!to && good));
    if (!to) m_hash = hv;
    chk("hash", 512'(hash_o), 512'(m_hash));
    chk("busy_resp", 512'(busy_o), 512'(1));
    if (to || !good) m_warn = 1'b1;
    else if (clr_resp) m_warn = 1'b0;
    warn_clr_i = clr_resp;
    @(negedge clk);
    warn_clr_i = 1'b0;
    lock_i = 1'b0;
    chk("done_clr", 512'(done_o), 512'(0));
    chk("gnt_clr", 512'(gnt_o), 512'(0));
    chk("busy_idle", 512'(busy_o), 512'(0));
    chk("warning", 512'(warning_o), 512'(m_warn));
  endtask

  initial begin
    fill_inputs();
    repeat (3) @(negedge clk);
    chk("rst_gnt", 512'(gnt_o), 512'(0));
    chk("rst_done", 512'(done_o), 512'(0));
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_warn", 512'(warning_o), 512'(0));
    chk("rst_init", 512'(core_init_o), 512'(0));
    chk("rst_data", core_data_o, 512'(0));
    chk("rst_hash", 512'(hash_o), 512'(0));
    rst = 1'b0;
    @(negedge clk);

    run_job(4'b0001, 0, 80, 1, 0, 0, 0);
    repeat (3) run_job(4'b0101, 0, 6, 1, 0, 0, 0);
    repeat (2) run_job(4'b1001, 1, 4, 1, 0, 0, 0);

    run_job(4'b0001, 0, 10, 0, 0, 0, 0);
    run_job(4'b0010, 0, 12, 1, 0, 0, 0);
    warn_clr_i = 1'b1;
    @(negedge clk);
    warn_clr_i = 1'b0;
    m_warn = 1'b0;
    chk("warn_cleared", 512'(warning_o), 512'(0));

    run_job(4'b0010, 0, T + 50, 1, 0, 0, 0);
    core_valid_i = 1'b1;
    run_job(4'b0100, 5, 6, 1, 0, 0, 0);
    run_job(4'b1000, 0, 5, 0, 1, 0, 0);

    lock_i = 1'b1;
    req_i  = 4'b0010;
    repeat (10) @(negedge clk);
    chk("lock_gnt", 512'(gnt_o), 512'(0));
    chk("lock_busy", 512'(busy_o), 512'(0));
    lock_i = 1'b0;
    run_job(4'b0010, 0, 8, 1, 0, 0, 0);

    req_i = 4'b0100;
    core_valid_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 512'(busy_o), 512'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", 512'(gnt_o), 512'(0));
    chk("arst_busy", 512'(busy_o), 512'(0));
    chk("arst_data", core_data_o, 512'(0));
    chk("arst_hash", 512'(hash_o), 512'(0));
    chk("arst_warn", 512'(warning_o), 512'(0));
    req_i = '0;
    m_ptr = 0;
    m_warn = 1'b0;
    m_hash = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 512'(busy_o), 512'(0));
    run_job(4'b1010, 0, 4, 1, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int s, g;
      s = int'($urandom_range(0, 6));
      g = ($urandom_range(0, 9) == 0) ? T + 20 : int'($urandom_range(2, 40));
      run_job(NR'($urandom_range(1, 15)), s, g, $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
